icache_lru_replacer: RTL and testbench

- Per-set true-LRU replacement engine for the instruction cache. Default geometry is 32 sets x 8 ways.
- Holds one age value per (set, way) and presents the victim way of the currently indexed set combinationally.
- Updates ages on cache accesses (hit or line fill) and on line invalidations.
- Sits beside the icache tag/data arrays. The cache controller drives idx/way/access/invalid and consumes rway_o when choosing a fill way.

---
 rtl/icache_lru_replacer.sv | 68 ++++++
 tb/tb_icache_lru_replacer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache_lru_replacer.sv
// True-LRU replacement state for the instruction cache: one age per (set, way),
// 0 = most recently used, NWAY-1 = victim. Victim of the indexed set is combinational.
module icache_lru_replacer #(
  parameter int NSET = 32,
  parameter int NWAY = 8,
  localparam int IW = $clog2(NSET),
  localparam int AW = $clog2(NWAY)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] idx,
  input  logic [AW-1:0] way,
  input  logic          access,
  input  logic          invalid,
  output logic [AW-1:0] rway_o
);

  typedef logic [AW-1:0] age_t;

  localparam age_t AGE_LRU = age_t'(NWAY - 1);

  age_t age     [NSET][NWAY];
  age_t cur_age [NWAY];
  age_t nxt_age [NWAY];
  age_t hit_age;

  always_comb begin
    for (int w = 0; w < NWAY; w++) cur_age[w] = age[idx][w];
  end

  assign hit_age = cur_age[way];

  // Exactly one way holds AGE_LRU while the permutation invariant holds.
  always_comb begin
    // NOTE: a default before the loop keeps this purely combinational (no latch when no way matches).
    rway_o = '0;
    for (int w = 0; w < NWAY; w++) begin
      if (cur_age[w] == AGE_LRU) rway_o = age_t'(w);
    end
  end

  // Access wins over invalidate; both preserve the permutation within the set.
  always_comb begin
    for (int w = 0; w < NWAY; w++) begin
      nxt_age[w] = cur_age[w];
      if (access) begin
        if (age_t'(w) == way)          nxt_age[w] = '0;
        else if (cur_age[w] < hit_age) nxt_age[w] = cur_age[w] + age_t'(1);
      end else if (invalid) begin
        if (age_t'(w) == way)          nxt_age[w] = AGE_LRU;
        else if (cur_age[w] > hit_age) nxt_age[w] = cur_age[w] - age_t'(1);
      end
    end
  end

  // NOTE: the age array is reset because the LRU permutation must be valid from the first access.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NSET; s++) begin
        for (int w = 0; w < NWAY; w++) age[s][w] <= age_t'(w);
      end
    end else if (access || invalid) begin
      // NOTE: non-blocking so every way reads the pre-edge ages of its neighbours.
      for (int w = 0; w < NWAY; w++) age[idx][w] <= nxt_age[w];
    end
  end

endmodule

// File: tb/tb_icache_lru_replacer.sv
// Bench for icache_lru_replacer: a recency-list model per set feeds a queue of
// expected victims; a negedge monitor pops and compares against rway_o.
module tb_icache_lru_replacer;

  localparam int NSET = 32;
  localparam int NWAY = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] idx;
  logic [2:0] way;
  logic       access;
  logic       invalid;
  logic [2:0] rway_o;

  icache_lru_replacer #(.NSET(NSET), .NWAY(NWAY)) dut (
    .clock   (clock),
    .reset   (reset),
    .idx     (idx),
    .way     (way),
    .access  (access),
    .invalid (invalid),
    .rway_o  (rway_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] exp;
    logic [4:0] idx;
    int         step;
  } exp_t;

  exp_t       sb_q[$];
  logic       chk_valid = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         step_no = 0;

  // Model: per set, the ways ordered from most to least recently used.
  logic [2:0] lst [NSET][$];

  task automatic model_reset();
    for (int s = 0; s < NSET; s++) begin
      lst[s].delete();
      for (int w = 0; w < NWAY; w++) lst[s].push_back(3'(w));
    end
  endtask

  task automatic model_remove(input int s, input logic [2:0] w);
    for (int k = 0; k < lst[s].size(); k++) begin
      if (lst[s][k] == w) begin
        lst[s].delete(k);
        break;
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp, input int extra);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, extra, got, exp);
    end
  endtask

  // One cycle: present inputs, expect the victim of idx under the pre-edge state.
  task automatic step(input logic r, input int i, input int w, input logic a, input logic inv);
    exp_t e;
    @(posedge clock);
    #1;
    reset   = r;
    idx     = 5'(i);
    way     = 3'(w);
    access  = a;
    invalid = inv;
    step_no++;
    e.exp  = lst[i][NWAY-1];
    e.idx  = 5'(i);
    e.step = step_no;
    sb_q.push_back(e);
    chk_valid = 1'b1;
    if (r) model_reset();
    else if (a) begin
      model_remove(i, 3'(w));
      lst[i].push_front(3'(w));
    end else if (inv) begin
      model_remove(i, 3'(w));
      lst[i].push_back(3'(w));
    end
  endtask

  task automatic look(input int i);
    step(1'b0, i, $urandom_range(0, 7), 1'b0, 1'b0);
  endtask

  always @(negedge clock) begin
    if (chk_valid) begin
      if (sb_q.size() == 0) begin
        check("rway_unexpected", 1, 0, step_no);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("rway idx=%0d", e.idx), int'(rway_o), int'(e.exp), e.step);
      end
    end
  end

  initial begin
    reset = 1'b1; idx = '0; way = '0; access = 1'b0; invalid = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);

    // Sweep after reset: every set reports way 7.
    for (int s = 0; s < NSET; s++) look(s);

    step(1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 3, 7, 1'b1, 1'b0);
    look(3);
    look(4);

    step(1'b1, 0, 0, 1'b0, 1'b0);
    for (int w = 0; w < NWAY; w++) step(1'b0, 5, w, 1'b1, 1'b0);
    look(5);
    step(1'b0, 5, 0, 1'b1, 1'b0);
    look(5);
    step(1'b0, 5, 0, 1'b1, 1'b0);
    look(5);

    step(1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 2, 7, 1'b1, 1'b0);
    step(1'b0, 2, 0, 1'b0, 1'b1);
    look(2);
    step(1'b0, 2, 6, 1'b0, 1'b1);
    look(2);
    step(1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 2, 7, 1'b1, 1'b0);
    step(1'b0, 2, 0, 1'b0, 1'b1);
    step(1'b0, 2, 0, 1'b0, 1'b1);
    look(2);

    step(1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 9, 7, 1'b1, 1'b1);
    look(9);

    // History in sets 1 and 3, then reset with a simultaneous access.
    for (int k = 0; k < 6; k++) step(1'b0, (k % 2) ? 3 : 1, 7 - k, 1'b1, 1'b0);
    look(1);
    look(3);
    step(1'b1, 1, 7, 1'b1, 1'b0);
    for (int s = 0; s < NSET; s++) look(s);

    // Randomized mix, weighted towards a few sets so history builds up.
    for (int n = 0; n < 3000; n++) begin
      int unsigned op;
      int i;
      logic a, inv;
      op = $urandom_range(0, 99);
      i  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, NSET - 1);
      a   = (op < 50);
      inv = (op >= 40 && op < 75);
      step((n % 250 == 249) ? 1'b1 : 1'b0, i, $urandom_range(0, 7), a, inv);
    end
    for (int s = 0; s < NSET; s++) look(s);

    @(posedge clock);
    #1;
    chk_valid = 1'b0;
    access    = 1'b0;
    invalid   = 1'b0;
    repeat (2) @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 0, step_no);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
